// File: rtl/rj_pkg.sv
// Shared types and helpers for the ring/Johnson sequencer.
// Latency: none (types, constants and a pure function).
// Backpressure: none.
package rj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    // Widest counter that legal_code() can inspect.
    localparam int MAX_W = 32;

    // Returns 1 when the low w bits of q are a code the given mode can reach:
    // ring needs exactly one bit set; Johnson needs at most one 0/1 boundary
    // between adjacent bits (0..01..1 or 1..10..0).
    function automatic logic legal_code(input logic mode,
                                        input logic [MAX_W-1:0] q,
                                        input int w);
        int ones;
        int trans;
        ones  = 0;
        trans = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && q[i]) begin
                ones = ones + 1;
            end
        end
        for (int i = 0; i < MAX_W - 1; i++) begin
            if ((i + 1) < w && q[i] != q[i+1]) begin
                trans = trans + 1;
            end
        end
        if (mode == MODE_RING) begin
            return (ones == 1);
        end
        return (trans <= 1);
    endfunction

endpackage

// File: rtl/rj_seq_ctrl_if.sv
// Command / status bundle between the control logic and the sequencer.
// Latency: none (wiring only).
// Backpressure: master holds cmd_valid until cmd_ready is seen high at an edge.
interface rj_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [CNT_W-1:0] cmd_steps;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    // Control side: issues commands, hold and abort; observes status.
    modport master (
        output cmd_valid, cmd_mode, cmd_steps, hold, abort,
        input  cmd_ready, q, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_mode, cmd_steps, hold, abort,
        output cmd_ready, q, busy, done, err
    );
endinterface

// File: rtl/rj_core.sv
// WIDTH-bit ring/Johnson shift register; no sequencing of its own.
// Latency: one cycle from clr/load/adv to q_o.
// Backpressure: none; priority is clr > load > adv, otherwise q holds.
module rj_core
    import rj_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             adv_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next counter value: clear, reload seed, or rotate (inverting feedback for Johnson).
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = seed_i;
        end else if (adv_i) begin
            if (mode_i == MODE_JOHNSON) begin
                q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            end else begin
                q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rj_seq_ctrl.sv
// Command-driven sequencer: load mode seed, advance N steps, pulse done; hold/abort/self-repair.
// Latency: accept at E, q=seed after E+1, last advance at E+1+N, done during the next cycle.
// Backpressure: cmd_ready only in IDLE with abort low; hold freezes RUN without losing steps.
module rj_seq_ctrl
    import rj_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    rj_seq_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic             core_clr;
    logic             core_load;
    logic             core_adv;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] core_q;
    logic             code_ok;

    // Ring starts from a single set LSB; Johnson starts from all zeros.
    assign seed    = (mode_q == MODE_RING) ? WIDTH'(1) : '0;
    assign code_ok = legal_code(mode_q, MAX_W'(core_q), WIDTH);

    rj_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (core_clr),
        .load_i (core_load),
        .seed_i (seed),
        .adv_i  (core_adv),
        .mode_i (mode_q),
        .q_o    (core_q)
    );

    // Next-state and datapath control; abort > illegal-code repair > hold > advance.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rem_d     = rem_q;
        err_d     = err_q;
        core_clr  = 1'b0;
        core_load = 1'b0;
        core_adv  = 1'b0;

        if (bus.abort) begin
            state_d  = IDLE;
            core_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // abort is low here, so cmd_ready is high
                    if (bus.cmd_valid) begin
                        mode_d  = bus.cmd_mode;
                        rem_d   = bus.cmd_steps;
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    core_load = 1'b1;
                    state_d   = (rem_q == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (!code_ok) begin
                        // Corrupted counter: flag it and restart the pattern; the
                        // outstanding step count is kept.
                        err_d     = 1'b1;
                        core_load = 1'b1;
                    end else if (!bus.hold) begin
                        core_adv = 1'b1;
                        if (rem_q != '0) begin
                            rem_d = rem_q - CNT_W'(1);
                        end
                        if (rem_q <= CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_RING;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) && !bus.abort;
    assign bus.busy      = (state_q == LOAD) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.q         = core_q;

endmodule

// File: tb/tb_rj_seq_ctrl.sv
module tb_rj_seq_ctrl;
    import rj_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rj_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

    rj_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    obs_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input logic [3:0] q, input logic b, input logic d, input logic e);
        obs_t o;
        o.q = q; o.busy = b; o.done = d; o.err = e;
        sb_q.push_back(o);
    endtask

    function automatic logic [3:0] model_adv(input logic m, input logic [3:0] v);
        return m ? {v[2:0], ~v[3]} : {v[2:0], v[3]};
    endfunction

    // Expected per-cycle status from the accept edge until back in IDLE.
    task automatic expect_run(input logic m, input int steps, input logic [3:0] old_q);
        logic [3:0] v;
        push(old_q, 1'b1, 1'b0, 1'b0);
        v = m ? 4'b0000 : 4'b0001;
        push(v, steps != 0, steps == 0, 1'b0);
        for (int k = 1; k <= steps; k++) begin
            v = model_adv(m, v);
            push(v, k < steps, k == steps, 1'b0);
        end
        push(v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic m, input logic [7:0] steps);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_steps = steps;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.q !== 4'b0000) begin n_err++; $display("FAIL reset_q: got %b want 0000", bus.q); end
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_ring();
        obs_t act, exp;
        push(4'b0000, 1, 0, 0);
        push(4'b0001, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0100, 1, 0, 0);
        push(4'b1000, 0, 1, 0);
        push(4'b1000, 0, 0, 0);
        push(4'b1000, 0, 0, 0);
        issue(MODE_RING, 8'd3);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL ring[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
        end
    endtask

    task automatic test_johnson();
        obs_t act, exp;
        logic [3:0] jseq [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        push(4'b1000, 1, 0, 0);
        for (int k = 0; k < 10; k++) push(jseq[k], k < 9, k == 9, 1'b0);
        push(4'b0001, 0, 0, 0);
        issue(MODE_JOHNSON, 8'd9);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL johnson[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
        end
    endtask

    task automatic test_hold();
        obs_t act, exp;
        push(4'b0001, 1, 0, 0);
        push(4'b0001, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0100, 1, 0, 0);
        push(4'b1000, 1, 0, 0);
        push(4'b0001, 0, 1, 0);
        push(4'b0001, 0, 0, 0);
        issue(MODE_RING, 8'd4);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL hold[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
            if (i == 2) bus.hold = 1'b1;
            if (i == 5) bus.hold = 1'b0;
        end
    endtask

    task automatic test_illegal();
        obs_t act, exp;
        push(4'b0001, 1, 0, 0);
        push(4'b0001, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        push(4'b0001, 1, 0, 1);
        push(4'b0010, 1, 0, 1);
        push(4'b0100, 1, 0, 1);
        push(4'b1000, 0, 1, 1);
        push(4'b1000, 0, 0, 1);
        issue(MODE_RING, 8'd4);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL illegal[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
            if (i == 2) begin
                @(negedge clk);
                force dut.u_core.q_q = 4'b0110;
                #1;
                release dut.u_core.q_q;
            end
        end
    endtask

    task automatic test_zero_steps();
        obs_t act, exp;
        expect_run(MODE_RING, 0, 4'b1000);
        issue(MODE_RING, 8'd0);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL zero_steps[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
        end
    endtask

    task automatic test_abort();
        obs_t act, exp;
        push(4'b0001, 1, 0, 0);
        push(4'b0001, 1, 0, 0);
        push(4'b0010, 1, 0, 0);
        issue(MODE_RING, 8'd5);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL abort_pre[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
        end
        // abort mid-RUN while a new command is already offered
        bus.abort = 1'b1;
        issue(MODE_JOHNSON, 8'd2);
        push(4'b0000, 0, 0, 0);
        push(4'b0000, 0, 0, 0);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp || bus.cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL abort_hold[%0d]: got q=%b busy=%b done=%b err=%b ready=%b want q=%b busy=%b done=%b err=%b ready=0",
                         i, act.q, act.busy, act.done, act.err, bus.cmd_ready, exp.q, exp.busy, exp.done, exp.err);
            end
        end
        bus.abort = 1'b0;
        #1;
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_release_ready: got %b want 1", bus.cmd_ready); end
        expect_run(MODE_JOHNSON, 2, 4'b0000);
        for (int i = 0; sb_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.cmd_valid = 1'b0;
            exp = sb_q.pop_front();
            act = {bus.q, bus.busy, bus.done, bus.err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL abort_post[%0d]: got q=%b busy=%b done=%b err=%b want q=%b busy=%b done=%b err=%b",
                         i, act.q, act.busy, act.done, act.err, exp.q, exp.busy, exp.done, exp.err);
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 1'b0;
        bus.cmd_steps = 8'd0;
        bus.hold      = 1'b0;
        bus.abort     = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_ring();
        test_johnson();
        test_hold();
        test_illegal();
        test_zero_steps();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
